// File: rtl/wakeup_queue.sv
// wakeup_queue: in-order circular buffer of renamed micro-ops feeding issue.
// Each stored op watches the writeback bus and sets its operand-ready flags
// (bits [7:4]) when a broadcast tag matches one of its four source tags.
// The head is offered on a valid/ready handshake. Gating on the flags is
// left to the issue stage.

`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

module wakeup_queue #(
    parameter int INST_WIDTH = `RENAMED_OP_SZ,
    parameter int TAG_W      = 6,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [INST_WIDTH-1:0]        in_instr,
    output logic                         in_ready,
    input  logic                         wb_valid,
    input  logic [TAG_W-1:0]             wb_tag,
    output logic                         out_valid,
    output logic [INST_WIDTH-1:0]        out_instr,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SRC_W = 4 * TAG_W;

    logic [INST_WIDTH-1:0] mem      [DEPTH];
    logic [INST_WIDTH-1:0] mem_next [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      offset;
    logic                  live;
    logic                  enq;
    logic                  deq;

    // Returns one ready bit per source whose tag equals the broadcast tag.
    function automatic logic [3:0] wake_mask(
        input logic [SRC_W-1:0] srcs,
        input logic             bus_valid,
        input logic [TAG_W-1:0] bus_tag
    );
        logic [3:0] m;
        m = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            m[k] = bus_valid && (srcs[k*TAG_W +: TAG_W] == bus_tag);
        end
        return m;
    endfunction

    // Handshake decode; in_ready and out_valid come only from registered count.
    always_comb begin
        in_ready  = (count != CNT_W'(DEPTH));
        out_valid = (count != '0);
        out_instr = mem[head];
        enq       = in_valid && in_ready;
        deq       = out_valid && out_ready;
    end

    // Next contents of every slot: wakeup of live entries, or a fresh write at the tail.
    always_comb begin
        // NOTE: every variable gets a value before any conditional use so no latch is inferred.
        offset = '0;
        live   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // Slot i is occupied when its distance from head is below count.
            offset      = PTR_W'(i) - head;
            live        = (CNT_W'(offset) < count) && !(deq && (PTR_W'(i) == head));
            mem_next[i] = mem[i];
            if (live) begin
                mem_next[i][7:4] = mem[i][7:4] | wake_mask(mem[i][8 +: SRC_W], wb_valid, wb_tag);
            end
            // The tail slot is never occupied while enqueueing, so the two cases never collide.
            if (enq && (PTR_W'(i) == tail)) begin
                mem_next[i]      = in_instr;
                mem_next[i][7:4] = in_instr[7:4] | wake_mask(in_instr[8 +: SRC_W], wb_valid, wb_tag);
            end
        end
    end

    // Storage registers; cleared on reset so out_instr reads zero from an empty queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage array is reset on purpose: out_instr must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_next[i];
            end
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + CNT_W'(1);
            end else if (deq && !enq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wakeup_queue.sv
// Self-checking bench for wakeup_queue: directed steps from the test plan
// followed by random traffic, all checked against a queue-based model.

module tb_wakeup_queue;

    localparam int IW    = 32;
    localparam int TW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic          in_ready;
    logic          wb_valid = 1'b0;
    logic [TW-1:0] wb_tag = '0;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic          out_ready = 1'b0;
    logic [2:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IW-1:0] model[$];

    wakeup_queue #(.INST_WIDTH(IW), .TAG_W(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk(input logic [5:0] t0, input logic [5:0] t1,
                                         input logic [5:0] t2, input logic [5:0] t3,
                                         input logic [3:0] flags, input logic [3:0] low);
        return {t3, t2, t1, t0, flags, low};
    endfunction

    // Reference wakeup: set flag k for every source k whose tag matches the broadcast.
    function automatic logic [IW-1:0] wake(input logic [IW-1:0] op, input logic v, input logic [TW-1:0] t);
        logic [IW-1:0] r;
        r = op;
        if (v) begin
            for (int k = 0; k < 4; k++) begin
                if (op[8 + k*TW +: TW] == t) r[4+k] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out_valid"}, IW'(out_valid), IW'(model.size() != 0));
        chk({tag, " in_ready"},  IW'(in_ready),  IW'(model.size() != DEPTH));
        chk({tag, " count"},     IW'(count),     IW'(model.size()));
        if (model.size() != 0) chk({tag, " out_instr"}, out_instr, model[0]);
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input string tag, input logic iv, input logic [IW-1:0] ii,
                        input logic orr, input logic wv, input logic [TW-1:0] wt);
        bit do_enq, do_deq;
        in_valid  = iv;
        in_instr  = ii;
        out_ready = orr;
        wb_valid  = wv;
        wb_tag    = wt;
        do_enq = iv && (model.size() < DEPTH);
        do_deq = orr && (model.size() > 0);
        if (do_deq) void'(model.pop_front());
        foreach (model[i]) model[i] = wake(model[i], wv, wt);
        if (do_enq) model.push_back(wake(ii, wv, wt));
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Assert reset between edges and check the asynchronous clear.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
        rst = 1'b1;
        #1;
        model.delete();
        check_model(tag);
        chk({tag, " out_instr zero"}, out_instr, '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    logic [IW-1:0] op_a, op_b, op_c, op_d, op_x;
    logic [IW-1:0] r;

    initial begin
        // Reset then idle.
        #3;
        mid_reset("reset");
        idle("idle0");
        idle("idle1");
        chk("idle out_instr", out_instr, '0);

        // Fill and drain, out_ready held low while filling.
        op_a = mk(6'd1, 6'd2, 6'd3, 6'd4, 4'b0001, 4'hA);
        op_b = mk(6'd11, 6'd12, 6'd13, 6'd14, 4'b0010, 4'hB);
        op_c = mk(6'd21, 6'd22, 6'd23, 6'd24, 4'b0100, 4'hC);
        op_d = mk(6'd31, 6'd32, 6'd33, 6'd34, 4'b1000, 4'hD);
        step("fill a", 1'b1, op_a, 1'b0, 1'b0, '0);
        step("fill b", 1'b1, op_b, 1'b0, 1'b0, '0);
        step("fill c", 1'b1, op_c, 1'b0, 1'b0, '0);
        step("fill d", 1'b1, op_d, 1'b0, 1'b0, '0);
        chk("full count", IW'(count), 32'd4);
        chk("full in_ready", IW'(in_ready), 32'd0);
        chk("full head", out_instr, op_a);
        step("fifth rejected", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        step("full no bypass", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
        chk("drain b", out_instr, op_b);
        step("drain c", 1'b0, '0, 1'b1, 1'b0, '0);
        chk("drain c head", out_instr, op_c);
        step("drain d", 1'b0, '0, 1'b1, 1'b0, '0);
        chk("drain d head", out_instr, op_d);
        step("drain end", 1'b0, '0, 1'b1, 1'b0, '0);
        chk("drained count", IW'(count), 32'd0);

        // Wrap-around with a steady occupancy of two.
        step("wrap pre0", 1'b1, mk(6'd40, 6'd41, 6'd42, 6'd43, 4'b0000, 4'h1), 1'b0, 1'b0, '0);
        step("wrap pre1", 1'b1, mk(6'd44, 6'd45, 6'd46, 6'd47, 4'b0000, 4'h2), 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            step("wrap", 1'b1, $urandom, 1'b1, 1'b0, '0);
            chk("wrap count", IW'(count), 32'd2);
        end
        step("wrap drain0", 1'b0, '0, 1'b1, 1'b0, '0);
        step("wrap drain1", 1'b0, '0, 1'b1, 1'b0, '0);

        // Wakeup of a stored entry.
        step("wk enq", 1'b1, mk(6'd5, 6'd9, 6'd5, 6'd0, 4'b1000, 4'h3), 1'b0, 1'b0, 6'd5);
        step("wk tag5", 1'b0, '0, 1'b0, 1'b1, 6'd5);
        r = out_instr; chk("wk flags 1101", IW'(r[7:4]), 32'hD);
        step("wk tag9", 1'b0, '0, 1'b0, 1'b1, 6'd9);
        r = out_instr; chk("wk flags 1111", IW'(r[7:4]), 32'hF);
        step("wk tag7", 1'b0, '0, 1'b0, 1'b1, 6'd7);
        r = out_instr; chk("wk flags hold", IW'(r[7:4]), 32'hF);
        step("wk deq", 1'b0, '0, 1'b1, 1'b0, '0);

        // Same-cycle capture on enqueue.
        step("cap on", 1'b1, mk(6'd12, 6'd50, 6'd51, 6'd52, 4'b1110, 4'h4), 1'b0, 1'b1, 6'd12);
        r = out_instr; chk("cap flags 1111", IW'(r[7:4]), 32'hF);
        step("cap deq", 1'b0, '0, 1'b1, 1'b0, '0);
        step("cap off", 1'b1, mk(6'd12, 6'd50, 6'd51, 6'd52, 4'b1110, 4'h4), 1'b0, 1'b0, 6'd12);
        r = out_instr; chk("cap flags 1110", IW'(r[7:4]), 32'hE);
        step("cap deq2", 1'b0, '0, 1'b1, 1'b0, '0);

        // Wakeup on the same edge the head leaves: only the next entry updates.
        step("sd enq0", 1'b1, mk(6'd20, 6'd1, 6'd1, 6'd1, 4'b0000, 4'h5), 1'b0, 1'b0, '0);
        step("sd enq1", 1'b1, mk(6'd2, 6'd20, 6'd2, 6'd2, 4'b0000, 4'h6), 1'b0, 1'b0, '0);
        step("sd enq2", 1'b1, mk(6'd3, 6'd3, 6'd3, 6'd3, 4'b0000, 4'h7), 1'b0, 1'b0, '0);
        step("sd deq wake", 1'b0, '0, 1'b1, 1'b1, 6'd20);
        r = out_instr; chk("sd next flags", IW'(r[7:4]), 32'h2);
        step("sd deq", 1'b0, '0, 1'b1, 1'b1, 6'd20);
        r = out_instr; chk("sd third untouched", IW'(r[7:4]), 32'h0);
        step("sd refill", 1'b1, mk(6'd4, 6'd4, 6'd4, 6'd4, 4'b0000, 4'h8), 1'b0, 1'b0, '0);
        step("sd refill2", 1'b1, mk(6'd8, 6'd8, 6'd8, 6'd8, 4'b0000, 4'h9), 1'b0, 1'b0, '0);
        chk("pre reset count", IW'(count), 32'd3);

        // Reset with entries present, then restart from slot 0.
        mid_reset("reset3");
        op_x = mk(6'd60, 6'd61, 6'd62, 6'd63, 4'b0101, 4'hE);
        step("post reset enq", 1'b1, op_x, 1'b0, 1'b0, '0);
        chk("post reset head", out_instr, op_x);
        step("post reset deq", 1'b0, '0, 1'b1, 1'b0, '0);

        // Random traffic with a narrow tag range so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0),
                 mk(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                    6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                    4'($urandom), 4'($urandom)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom), 6'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wakeup_queue.md
# wakeup_queue

In-order buffer of renamed micro-ops that feeds the issue stage. Each entry holds one renamed op whose four operand-ready flags (instr[7:4]) are set as matching result tags are broadcast on the writeback bus. The head entry is presented on a valid/ready handshake to the issue-gating stage. That stage holds the op until all four flags are set, then consumes it when the downstream unit is ready.

## Interface
- INST_WIDTH, default `RENAMED_OP_SZ: renamed-op width.
- TAG_W, default 6: physical-register tag width. Source k tag is at instr[8 + k*TAG_W +: TAG_W], k = 0..3. Requires INST_WIDTH >= 8 + 4*TAG_W.
- DEPTH, default 4: entry count. Must be a power of two, >= 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  rename stage offers in_instr.
- in_instr  input  INST_WIDTH  renamed op; bits [7:4] are the initial ready flags.
- in_ready  output  1  queue can accept this cycle.
- wb_valid  input  1  result broadcast valid.
- wb_tag  input  TAG_W  tag of the broadcast result.
- out_valid  output  1  head entry occupied.
- out_instr  output  INST_WIDTH  head entry contents, including current ready flags.
- out_ready  input  1  issue stage consumes the head.
- count  output  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a circular buffer with head pointer, tail pointer and occupancy count. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Enqueue happens when in_valid & in_ready. in_instr is written at the tail and the tail advances.
- Dequeue happens when out_valid & out_ready. The head advances. Entry contents are not cleared.
- Enqueue and dequeue in the same cycle leave count unchanged and move both pointers.
- in_ready = (count != DEPTH). A dequeue does not bypass a full queue: when full, in_ready is 0 even if out_ready is 1.
- out_valid = (count != 0). out_instr = storage[head], driven combinationally from the registers.
- Wakeup applies on wb_valid:
  - For every occupied entry not being dequeued this cycle, each source k whose tag equals wb_tag has ready bit 4+k set.
  - The same compare runs on in_instr when it is enqueued that cycle. The stored value is in_instr with the matching bits set.
  - Multiple sources in one entry may match at once; all are set.
- Ready bits are only ever set, never cleared. Bits already 1 stay 1. Ops carrying fewer than four sources arrive with the unused flags preset to 1 by rename.
- Only bits [7:4] are modified after enqueue. All other bits are stored verbatim.
- Writeback to an empty queue has no effect.
- wb_valid=0 leaves all entries unchanged.
- The queue does not inspect ready flags when deciding out_valid. Gating on the flags is the issue stage's job.

## Timing
- Reset (async, immediate) sets: head=0, tail=0, count=0, out_valid=0, in_ready=1, all storage=0, so out_instr=0.
- Reset mid-operation discards all entries. The first edge after rst falls behaves as from an empty queue.
- Enqueue-to-out_valid latency is 1 cycle. There is no empty-queue bypass.
- A wakeup is visible on out_instr on the cycle after the wb_valid edge.
- A wakeup on the same edge as enqueue is captured. A wakeup on the same edge as dequeue of that entry is lost, which is harmless because the entry has left.
- No combinational path from out_ready or wb_* to out_valid, out_instr or in_ready. in_ready depends only on registered count.

## Test plan
- Reset then idle:
  - Assert rst mid-cycle -> out_valid=0, in_ready=1, count=0, out_instr=0 immediately.
  - Deassert, no stimulus -> unchanged.
- Fill/drain with DEPTH=4, out_ready=0:
  - Enqueue A,B,C,D on 4 edges -> count=4, in_ready=0, out_instr=A.
  - Fifth in_valid -> not accepted.
  - Drain with out_ready=1 -> A,B,C,D in order, then count=0.
- Wrap-around:
  - With count=2 steady, run 10 cycles of simultaneous enqueue/dequeue -> count stays 2, FIFO order preserved across pointer wrap.
- Wakeup of stored entry:
  - Enqueue op with src tags 5,9,5,0 and flags 4'b1000.
  - wb_valid, wb_tag=5 -> next cycle flags=4'b1101.
  - wb_tag=9 -> flags=4'b1111.
  - wb_tag=7 -> no change.
- Same-cycle capture:
  - Enqueue op (src0 tag 12, flags 4'b1110) while wb_tag=12 -> stored flags=4'b1111.
  - Same with wb_valid=0 -> flags 4'b1110.
- Same-cycle dequeue and reset:
  - wb_tag matching the head while out_ready=1 -> head leaves, next entry updated only if it matches.
  - Assert rst with count=3 -> count=0 asynchronously, later enqueues start at slot 0.
